// File: rtl/sign_extend_pkg.sv
// Shared constants for the sign_extend block: select encodings and datapath widths.
package sign_extend_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    localparam logic SEL_BYTE = 1'b0;
    localparam logic SEL_HALF = 1'b1;

endpackage

// File: rtl/sign_extend_sext_unit.sv
// Combinational extension of the immediate and of byte/half-word load data.
// SIGN_EXTEND_ZEXT_EN enables the zero_ext (unsigned load) input.
module sext_unit
    import sign_extend_pkg::*;
(
    input  logic [IMM_W-1:0]  immediate,
    input  logic [WORD_W-1:0] data_readdata,
    input  logic              select,
    input  logic              zero_ext,
    output logic [WORD_W-1:0] ext_imm,
    output logic [WORD_W-1:0] ext_data
);

    logic use_zext;
    logic fill;
    logic unused_bits;

`ifdef SIGN_EXTEND_ZEXT_EN
    assign use_zext = zero_ext;
`else
    logic unused_zext;
    assign unused_zext = zero_ext;
    assign use_zext    = 1'b0;
`endif

    // Upper load bits never reach the result for either width.
    assign unused_bits = ^data_readdata[WORD_W-1:16];

    assign ext_imm = {{(WORD_W-IMM_W){immediate[IMM_W-1]}}, immediate};

    always_comb begin
        fill     = 1'b0;
        ext_data = '0;
        if (select == SEL_HALF) begin
            fill     = data_readdata[15] & ~use_zext;
            ext_data = {{16{fill}}, data_readdata[15:0]};
        end else begin
            fill     = data_readdata[7] & ~use_zext;
            ext_data = {{24{fill}}, data_readdata[7:0]};
        end
    end

endmodule

// File: rtl/sign_extend.sv
// Registered sign/zero extension stage with a one-cycle valid pipeline.
// Optional zero extension of load data is enabled by SIGN_EXTEND_ZEXT_EN.
module sign_extend
    import sign_extend_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [WORD_W-1:0] data_readdata,
    input  logic              select,
    input  logic              zero_ext,
    input  logic              in_valid,
    output logic [WORD_W-1:0] extended_imm,
    output logic [WORD_W-1:0] extended_data,
    output logic              out_valid
);

    logic [WORD_W-1:0] ext_imm;
    logic [WORD_W-1:0] ext_data;

    sext_unit u_sext_unit (
        .immediate     (immediate),
        .data_readdata (data_readdata),
        .select        (select),
        .zero_ext      (zero_ext),
        .ext_imm       (ext_imm),
        .ext_data      (ext_data)
    );

    // Data registers hold while idle; valid tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extended_imm  <= '0;
            extended_data <= '0;
            out_valid     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                extended_imm  <= ext_imm;
                extended_data <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Table-driven self-checking bench for sign_extend, plus hold/back-to-back/reset sequences.
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [15:0] immediate;
    logic [31:0] data_readdata;
    logic        select;
    logic        zero_ext;
    logic        in_valid;
    logic [31:0] extended_imm;
    logic [31:0] extended_data;
    logic        out_valid;

    int total;
    int bad;

    typedef struct {
        logic [15:0] imm;
        logic [31:0] data;
        logic        sel;
        logic        zext;
        logic [31:0] exp_imm;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    sign_extend dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .immediate     (immediate),
        .data_readdata (data_readdata),
        .select        (select),
        .zero_ext      (zero_ext),
        .in_valid      (in_valid),
        .extended_imm  (extended_imm),
        .extended_data (extended_data),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] imm, input logic [31:0] data, input logic sel,
                         input logic zext, input logic vld);
        immediate     = imm;
        data_readdata = data;
        select        = sel;
        zero_ext      = zext;
        in_valid      = vld;
    endtask

    // Drive after a negedge, let one rising edge pass, sample on the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{16'hffff, 32'h0000fff0, 1'b0, 1'b0, 32'hffffffff, 32'hfffffff0};
        vecs[1] = '{16'h00ff, 32'h0000000f, 1'b0, 1'b0, 32'h000000ff, 32'h0000000f};
        vecs[2] = '{16'hc84d, 32'h0000fff0, 1'b1, 1'b0, 32'hffffc84d, 32'hfffffff0};
        vecs[3] = '{16'h7aec, 32'h000029c7, 1'b1, 1'b0, 32'h00007aec, 32'h000029c7};
        vecs[4] = '{16'h8000, 32'hdeadbe7f, 1'b0, 1'b0, 32'hffff8000, 32'h0000007f};
        vecs[5] = '{16'h0001, 32'h12348001, 1'b1, 1'b0, 32'h00000001, 32'hffff8001};
        vecs[6] = '{16'h0080, 32'hffffff80, 1'b1, 1'b0, 32'h00000080, 32'hffffff80};
`ifdef SIGN_EXTEND_ZEXT_EN
        vecs[7] = '{16'h1234, 32'h000080f0, 1'b0, 1'b1, 32'h00001234, 32'h000000f0};
        vecs[8] = '{16'hfedc, 32'h000080f0, 1'b1, 1'b1, 32'hfffffedc, 32'h000080f0};
`else
        vecs[7] = '{16'h1234, 32'h000080f0, 1'b0, 1'b1, 32'h00001234, 32'hfffffff0};
        vecs[8] = '{16'hfedc, 32'h000080f0, 1'b1, 1'b1, 32'hfffffedc, 32'hffff80f0};
`endif

        // Reset with valid inputs present: outputs must stay zero.
        rst_n = 1'b0;
        drive(16'hffff, 32'hffffffff, 1'b1, 1'b0, 1'b1);
        step();
        check("reset_imm", extended_imm, 32'h0);
        check("reset_data", extended_data, 32'h0);
        check("reset_valid", {31'b0, out_valid}, 32'h0);

        rst_n = 1'b1;
        drive(16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("post_reset_idle_valid", {31'b0, out_valid}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].imm, vecs[i].data, vecs[i].sel, vecs[i].zext, 1'b1);
            step();
            check($sformatf("vec%0d_imm", i), extended_imm, vecs[i].exp_imm);
            check($sformatf("vec%0d_data", i), extended_data, vecs[i].exp_data);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
        end

        // Idle cycle with changed inputs: registers hold last result.
        drive(16'h1111, 32'h00000022, 1'b0, 1'b0, 1'b0);
        step();
        check("hold_imm", extended_imm, vecs[8].exp_imm);
        check("hold_data", extended_data, vecs[8].exp_data);
        check("hold_valid", {31'b0, out_valid}, 32'h0);

        // Back-to-back valid inputs each produce one result.
        drive(vecs[0].imm, vecs[0].data, vecs[0].sel, 1'b0, 1'b1);
        step();
        check("b2b0_data", extended_data, vecs[0].exp_data);
        check("b2b0_valid", {31'b0, out_valid}, 32'h1);
        drive(vecs[3].imm, vecs[3].data, vecs[3].sel, 1'b0, 1'b1);
        step();
        check("b2b1_imm", extended_imm, vecs[3].exp_imm);
        check("b2b1_data", extended_data, vecs[3].exp_data);
        check("b2b1_valid", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset mid-stream, away from any clock edge.
        drive(vecs[2].imm, vecs[2].data, vecs[2].sel, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_imm", extended_imm, 32'h0);
        check("async_rst_data", extended_data, 32'h0);
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        step();
        rst_n = 1'b1;
        drive(16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("discard_inflight_data", extended_data, 32'h0);
        check("discard_inflight_valid", {31'b0, out_valid}, 32'h0);

        drive(vecs[5].imm, vecs[5].data, vecs[5].sel, 1'b0, 1'b1);
        step();
        check("first_after_rst_imm", extended_imm, vecs[5].exp_imm);
        check("first_after_rst_data", extended_data, vecs[5].exp_data);
        check("first_after_rst_valid", {31'b0, out_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
SIGN_EXTEND -- requirements
Module: sign_extend

Interface
- REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst_n  input  1  asynchronous active-low reset.
- REQ-004 immediate  input  16  instruction immediate field.
- REQ-005 data_readdata  input  32  raw load data from memory.
- REQ-006 select  input  1  data width: 0 = byte (bits 7:0), 1 = half word (bits 15:0).
- REQ-007 zero_ext  input  1  1 = zero-extend data (unsigned load); honoured only with SIGN_EXTEND_ZEXT_EN.
- REQ-008 in_valid  input  1  inputs are valid this cycle.
- REQ-009 extended_imm  output  32  registered 32-bit sign-extended immediate.
- REQ-010 extended_data  output  32  registered 32-bit extended load data.
- REQ-011 out_valid  output  1  extended outputs are valid.

Function
- REQ-012 extended_imm SHALL be {16{immediate[15]}, immediate} regardless of select.
- REQ-013 With select=0, extended_data SHALL be {24{data_readdata[7]}, data_readdata[7:0]}; bits 31:8 of the input are ignored.
- REQ-014 With select=1, extended_data SHALL be {16{data_readdata[15]}, data_readdata[15:0]}; bits 31:16 of the input are ignored.
- REQ-015 Latency SHALL be exactly one clock: values sampled on edge N appear on the outputs after edge N.
- REQ-016 out_valid SHALL equal in_valid delayed by one cycle.
- REQ-017 Output registers SHALL load only when in_valid=1 and SHALL hold their value when in_valid=0.
- REQ-018 Back-to-back in_valid=1 cycles SHALL each produce one result; there is no stall or backpressure.

Reset
- REQ-019 While rst_n=0, extended_imm, extended_data and out_valid SHALL be 0, asynchronously.
- REQ-020 An in-flight input at reset assertion SHALL be discarded.
- REQ-021 The first valid output after reset release SHALL come from the first in_valid=1 edge after release.

Configuration
- REQ-022 When SIGN_EXTEND_ZEXT_EN is defined, zero_ext=1 SHALL replace the sign bit with 0 in the data extension only, for both widths; extended_imm is unaffected.
- REQ-023 When SIGN_EXTEND_ZEXT_EN is undefined, zero_ext SHALL be ignored and treated as 0.

Structure
- REQ-024 Package sign_extend_pkg SHALL hold the select encodings SEL_BYTE=1'b0 and SEL_HALF=1'b1, plus width constants IMM_W=16 and WORD_W=32.
- REQ-025 A combinational sub-module sext_unit SHALL perform the extension; sign_extend SHALL add the register stage and valid pipeline around it.

Verification
- REQ-026 immediate=16'hffff, data=32'hfff0, select=0, in_valid=1 -> next cycle: imm=32'hffffffff, data=32'hfffffff0, out_valid=1.
- REQ-027 immediate=16'h00ff, data=32'h000f, select=0 -> imm=32'h000000ff, data=32'h0000000f.
- REQ-028 immediate=16'hc84d, data=32'hfff0, select=1 -> imm=32'hffffc84d, data=32'hfffffff0; immediate=16'h7aec, data=32'h29c7 -> imm=32'h00007aec, data=32'h000029c7.
- REQ-029 in_valid=0 with changed inputs -> outputs hold their previous values and out_valid=0; asserting rst_n=0 mid-stream clears all outputs to 0 immediately, with no clock edge.
- REQ-030 With SIGN_EXTEND_ZEXT_EN, zero_ext=1, data=32'h80f0, select=0 -> data=32'h000000f0; select=1 -> data=32'h000080f0.
